// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Opcode encoding and level-to-stage mapping for shift_rotate_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam int c_OP_W = 3;

    typedef enum logic [c_OP_W-1:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } op_e;

    // Log-shifter level k (shift by 2^k) belongs to this pipeline stage.
    function automatic int stage_of_level(input int k, input int stages, input int levels);
        return (k * stages) / levels;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage
// Description : One pipeline stage: its share of log-shifter levels plus a
//               valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int STAGES    = 2,
    parameter int TAG_W     = 3,
    parameter int STAGE_IDX = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_carry,
    input  logic [c_OP_W-1:0]        in_op,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic [c_OP_W-1:0]        out_op,
    output logic [$clog2(WIDTH)-1:0] out_amt,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int               c_LVLS = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic              carry;
        logic              zero;
        logic [c_OP_W-1:0] op;
        logic [c_LVLS-1:0] amt;
        logic [TAG_W-1:0]  tag;
    } payload_t;

    payload_t         r_pay;
    payload_t         w_next;
    logic             r_valid;
    logic [WIDTH-1:0] w_d [c_LVLS+1];
    logic [c_LVLS:0]  w_c;

    assign w_d[0] = in_data;
    assign w_c[0] = in_carry;

    for (genvar k = 0; k < c_LVLS; k++) begin : g_lvl
        localparam int               c_SH     = 1 << k;
        localparam bit               c_ACTIVE = (stage_of_level(k, STAGES, c_LVLS) == STAGE_IDX);
        localparam logic [WIDTH-1:0] c_HI     = c_ONE << (WIDTH - c_SH);
        localparam logic [WIDTH-1:0] c_LO     = c_ONE << (c_SH - 1);

        logic [WIDTH-1:0] w_res;
        logic             w_cout;

        // Carry is the last bit to leave; it survives levels that do not shift.
        always_comb begin
            w_res  = w_d[k];
            w_cout = w_c[k];
            case (in_op)
                OP_SLL: begin
                    w_res  = w_d[k] << c_SH;
                    w_cout = |(w_d[k] & c_HI);
                end
                OP_SRL: begin
                    w_res  = w_d[k] >> c_SH;
                    w_cout = |(w_d[k] & c_LO);
                end
                OP_SRA: begin
                    w_res  = $signed(w_d[k]) >>> c_SH;
                    w_cout = |(w_d[k] & c_LO);
                end
                OP_ROL: begin
                    w_res  = (w_d[k] << c_SH) | (w_d[k] >> (WIDTH - c_SH));
                    w_cout = |(w_d[k] & c_HI);
                end
                OP_ROR: begin
                    w_res  = (w_d[k] >> c_SH) | (w_d[k] << (WIDTH - c_SH));
                    w_cout = |(w_d[k] & c_LO);
                end
                default: ;
            endcase
        end

        assign w_d[k+1] = (c_ACTIVE && in_amt[k]) ? w_res  : w_d[k];
        assign w_c[k+1] = (c_ACTIVE && in_amt[k]) ? w_cout : w_c[k];
    end

    always_comb begin
        w_next       = '0;
        w_next.data  = w_d[c_LVLS];
        w_next.carry = w_c[c_LVLS];
        w_next.zero  = (w_d[c_LVLS] == '0);
        w_next.op    = in_op;
        w_next.amt   = in_amt;
        w_next.tag   = in_tag;
    end

    assign in_ready = !r_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_pay   <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (in_ready) begin
                r_valid <= in_valid;
            end
            if (in_valid && in_ready && !flush) begin
                r_pay <= w_next;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_pay.data;
    assign out_carry = r_pay.carry;
    assign out_zero  = r_pay.zero;
    assign out_op    = r_pay.op;
    assign out_amt   = r_pay.amt;
    assign out_tag   = r_pay.tag;

endmodule
`default_nettype wire

// File: rtl/shift_rotate_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_rotate_pipe
// Description : Pipelined shift/rotate unit with valid/ready handshake, flush
//               and a sideband tag.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rotate_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int TAG_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [c_OP_W-1:0]        in_op,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int c_AMT_W = $clog2(WIDTH);

    logic [STAGES:0]    w_valid;
    logic [STAGES:0]    w_carry;
    logic [STAGES-1:0]  w_zero;
    logic [STAGES-1:0]  w_rdy;
    logic [STAGES-1:0]  w_down_ready;
    logic [WIDTH-1:0]   w_data [STAGES+1];
    logic [c_OP_W-1:0]  w_op   [STAGES+1];
    logic [c_AMT_W-1:0] w_amt  [STAGES+1];
    logic [TAG_W-1:0]   w_tag  [STAGES+1];
    logic               w_unused;

    assign w_valid[0] = in_valid;
    assign w_carry[0] = 1'b0;
    assign w_data[0]  = in_data;
    assign w_op[0]    = in_op;
    assign w_amt[0]   = in_amt;
    assign w_tag[0]   = in_tag;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        // A stage may advance if the output accepts or any later stage has a hole.
        if (s + 2 <= STAGES) begin : g_mid
            assign w_down_ready[s] = out_ready || !(&w_valid[STAGES:s+2]);
        end else begin : g_last
            assign w_down_ready[s] = out_ready;
        end

        shift_stage #(
            .WIDTH     (WIDTH),
            .STAGES    (STAGES),
            .TAG_W     (TAG_W),
            .STAGE_IDX (s)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (w_valid[s]),
            .in_ready  (w_rdy[s]),
            .in_data   (w_data[s]),
            .in_carry  (w_carry[s]),
            .in_op     (w_op[s]),
            .in_amt    (w_amt[s]),
            .in_tag    (w_tag[s]),
            .out_valid (w_valid[s+1]),
            .out_ready (w_down_ready[s]),
            .out_data  (w_data[s+1]),
            .out_carry (w_carry[s+1]),
            .out_zero  (w_zero[s]),
            .out_op    (w_op[s+1]),
            .out_amt   (w_amt[s+1]),
            .out_tag   (w_tag[s+1])
        );
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = w_valid[STAGES];
    assign out_data  = w_data[STAGES];
    assign out_carry = w_carry[STAGES];
    assign out_zero  = w_zero[STAGES-1];
    assign out_tag   = w_tag[STAGES];

    // Final op/amount and interior zero/ready flags have no consumer.
    assign w_unused = ^{w_op[STAGES], w_amt[STAGES], w_zero, w_rdy};

endmodule
`default_nettype wire

// File: tb/tb_shift_rotate_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_rotate_pipe
// Description : Self-checking bench for shift_rotate_pipe (WIDTH=16, STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_rotate_pipe;

    localparam int WIDTH  = 16;
    localparam int STAGES = 2;
    localparam int TAG_W  = 3;

    logic        clk, rst, in_valid, in_ready, flush;
    logic        out_valid, out_ready, out_carry, out_zero;
    logic [15:0] in_data, out_data;
    logic [3:0]  in_amt;
    logic [2:0]  in_op, in_tag, out_tag;

    int n_cmp  = 0;
    int n_fail = 0;

    shift_rotate_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole-amount reference: {carry, result}
    function automatic logic [16:0] ref_op(input logic [2:0] op, input logic [15:0] d, input int a);
        logic [15:0] r;
        logic        c;
        r = d;
        c = 1'b0;
        if (a != 0) begin
            case (op)
                3'd0: begin r = d << a; c = d[4'(16 - a)]; end
                3'd1: begin r = d >> a; c = d[4'(a - 1)]; end
                3'd2: begin r = 16'($signed(d) >>> a); c = d[4'(a - 1)]; end
                3'd3: begin r = (d << a) | (d >> (16 - a)); c = r[0]; end
                3'd4: begin r = (d >> a) | (d << (16 - a)); c = r[15]; end
                default: begin r = d; c = 1'b0; end
            endcase
        end
        return {c, r};
    endfunction

    task automatic drive(input logic [2:0] op, input logic [15:0] d, input logic [3:0] a, input logic [2:0] t);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        in_tag   = t;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 16'h0)   begin n_fail++; $display("FAIL reset_data: got %h want 0000", out_data); end
        n_cmp++; if (out_carry !== 1'b0)   begin n_fail++; $display("FAIL reset_carry: got %0b want 0", out_carry); end
        n_cmp++; if (out_zero !== 1'b0)    begin n_fail++; $display("FAIL reset_zero: got %0b want 0", out_zero); end
        n_cmp++; if (out_tag !== 3'd0)     begin n_fail++; $display("FAIL reset_tag: got %0d want 0", out_tag); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [6];
        logic [15:0] t_d  [6];
        logic [3:0]  t_a  [6];
        logic [15:0] t_e  [6];
        logic        t_z  [6];
        t_op = '{3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd1};
        t_d  = '{16'h8FFF, 16'h8FFF, 16'h8FFF, 16'h8001, 16'h0001, 16'h0001};
        t_a  = '{4'd4, 4'd4, 4'd15, 4'd1, 4'd1, 4'd1};
        t_e  = '{16'h08FF, 16'hF8FF, 16'h8000, 16'h0003, 16'h8000, 16'h0000};
        t_z  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(t_op[i], t_d[i], t_a[i], 3'(i));
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid: got %0b want 0", i, out_valid); end
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_valid: got %0b want 1", i, out_valid); end
            n_cmp++; if (out_data !== t_e[i]) begin n_fail++; $display("FAIL dir%0d_data: got %h want %h", i, out_data, t_e[i]); end
            n_cmp++; if (out_carry !== 1'b1) begin n_fail++; $display("FAIL dir%0d_carry: got %0b want 1", i, out_carry); end
            n_cmp++; if (out_zero !== t_z[i]) begin n_fail++; $display("FAIL dir%0d_zero: got %0b want %0b", i, out_zero, t_z[i]); end
            n_cmp++; if (out_tag !== 3'(i)) begin n_fail++; $display("FAIL dir%0d_tag: got %0d want %0d", i, out_tag, i); end
        end
    endtask

    task automatic test_sweep();
        localparam int N = 256;
        logic [2:0]  s_op  [N];
        logic [15:0] s_d   [N];
        logic [3:0]  s_a   [N];
        logic [2:0]  s_tag [N];
        logic [16:0] s_exp [N];
        for (int i = 0; i < N; i++) begin
            s_op[i]  = 3'((i / 16) % 8);
            s_a[i]   = 4'(i % 16);
            s_d[i]   = (i < 128) ? 16'h8FFF : 16'($urandom);
            s_tag[i] = 3'($urandom);
            s_exp[i] = ref_op(s_op[i], s_d[i], int'(s_a[i]));
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < N + 2; cyc++) begin
            @(posedge clk); #1;
            if (cyc < N) drive(s_op[cyc], s_d[cyc], s_a[cyc], s_tag[cyc]);
            else         in_valid = 1'b0;
            @(negedge clk);
            if (cyc < N) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready c%0d: got %0b want 1", cyc, in_ready); end
            end
            if (cyc >= 2) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== s_exp[cyc-2][15:0] || out_carry !== s_exp[cyc-2][16]
                    || out_zero !== (s_exp[cyc-2][15:0] == 16'h0) || out_tag !== s_tag[cyc-2]) begin
                    n_fail++;
                    $display("FAIL sweep op%0d amt%0d d=%h: got v%0b %h c%0b z%0b t%0d want v1 %h c%0b z%0b t%0d",
                             s_op[cyc-2], s_a[cyc-2], s_d[cyc-2], out_valid, out_data, out_carry, out_zero, out_tag,
                             s_exp[cyc-2][15:0], s_exp[cyc-2][16], (s_exp[cyc-2][15:0] == 16'h0), s_tag[cyc-2]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [2:0]  st_op [3];
        logic [15:0] st_d  [3];
        logic [3:0]  st_a  [3];
        logic [16:0] st_e  [3];
        int k   = 0;
        int got = 0;
        for (int i = 0; i < 3; i++) begin
            st_op[i] = 3'($urandom_range(0, 4));
            st_d[i]  = 16'($urandom) | 16'h0100;
            st_a[i]  = 4'($urandom_range(1, 7));
            st_e[i]  = ref_op(st_op[i], st_d[i], int'(st_a[i]));
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 4);
            if (k < 3) drive(st_op[k], st_d[k], st_a[k], 3'(k + 1));
            else       in_valid = 1'b0;
            @(negedge clk);
            if (cyc == 2 || cyc == 3) begin
                n_cmp++; if (k !== 2) begin n_fail++; $display("FAIL stall_accepted c%0d: got %0d want 2", cyc, k); end
                n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c%0d: got %0b want 0", cyc, in_ready); end
                n_cmp++;
                if (out_valid !== 1'b1 || out_tag !== 3'd1 || out_data !== st_e[0][15:0] || out_carry !== st_e[0][16]) begin
                    n_fail++;
                    $display("FAIL stall_hold c%0d: got v%0b t%0d %h c%0b want v1 t1 %h c%0b",
                             cyc, out_valid, out_tag, out_data, out_carry, st_e[0][15:0], st_e[0][16]);
                end
            end
            if (in_valid && in_ready) k++;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_tag !== 3'(got + 1) || out_data !== st_e[got][15:0] || out_carry !== st_e[got][16]) begin
                    n_fail++;
                    $display("FAIL stall_order #%0d: got t%0d %h c%0b want t%0d %h c%0b",
                             got, out_tag, out_data, out_carry, got + 1, st_e[got][15:0], st_e[got][16]);
                end
                got++;
            end
            if (got == 3) break;
        end
        in_valid = 1'b0;
        n_cmp++; if (got !== 3) begin n_fail++; $display("FAIL stall_delivered: got %0d want 3", got); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        @(posedge clk); #1;
        drive(3'd3, 16'h1234, 4'd3, 3'd5);
        @(posedge clk); #1;
        drive(3'd1, 16'hABCD, 4'd2, 3'd6);
        @(posedge clk); #1;
        drive(3'd0, 16'h00F0, 4'd1, 3'd7);
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_next_valid: got %0b want 0", out_valid); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak c%0d: got valid tag %0d want none", i, out_tag); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [2:0]  op;
        logic [15:0] d;
        logic [3:0]  a;
        logic [16:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(3'd5, 16'hFFFF, 4'($urandom), 3'd7);
        end
        @(posedge clk); #3;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h want 0000", out_data); end
        n_cmp++; if (out_tag !== 3'd0)   begin n_fail++; $display("FAIL rst_mid_tag: got %0d want 0", out_tag); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_mid_in_ready: got %0b want 1", in_ready); end
        op = 3'($urandom_range(0, 4));
        d  = 16'($urandom);
        a  = 4'($urandom_range(1, 15));
        e  = ref_op(op, d, int'(a));
        @(posedge clk); #1;
        drive(op, d, a, 3'd4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_early: got %0b want 0", out_valid); end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== e[15:0] || out_carry !== e[16] || out_tag !== 3'd4) begin
            n_fail++;
            $display("FAIL rst_mid_first: got v%0b %h c%0b t%0d want v1 %h c%0b t4",
                     out_valid, out_data, out_carry, out_tag, e[15:0], e[16]);
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_directed();
        test_sweep();
        test_stall();
        test_flush();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
